// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard stall and bubble injection.
// Optional HAZARD_STATS_EN adds a saturating stall_cycle_count output.
//
// state | meaning
// RUN   | normal flow: capture ID, or start a load-use stall
// STALL | extra bubbles after the first load-use bubble, counted down in cnt
module id_ex_hazard_stage #(
  parameter int XLEN              = 32,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_is_writeback,
  input  logic            id_is_load,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [4:0]      ex_rs1_field,
  output logic [4:0]      ex_rs2_field,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_is_writeback,
  output logic            ex_is_load,
  output logic            pc_write_en,
  output logic            if_id_write_en,
  output logic            stall_active
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycle_count
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hz;
  logic       capture;

  assign hz = id_valid & ex_valid & ex_is_load & ex_is_writeback &
              (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (state == RUN) begin
      if (ex_flush) begin
        state_nxt = RUN;
      end else if (hz) begin
        cnt_nxt   = STALL_INIT;
        state_nxt = (STALL_INIT != 3'd0) ? STALL : RUN;
      end else begin
        capture = 1'b1;
      end
    end else begin
      if (ex_flush) begin
        cnt_nxt   = 3'd0;
        state_nxt = RUN;
      end else begin
        cnt_nxt   = cnt - 3'd1;
        state_nxt = (cnt <= 3'd1) ? RUN : STALL;
      end
    end
  end

  // A flush cancels the stall in the same cycle it is seen.
  always_comb begin
    stall_active   = ((state == RUN) ? hz : 1'b1) & ~ex_flush;
    pc_write_en    = ~stall_active;
    if_id_write_en = ~stall_active;
  end

  always_ff @(posedge clk) begin
    if (reset || !capture) begin
      ex_valid        <= 1'b0;
      ex_rs1_field    <= 5'd0;
      ex_rs2_field    <= 5'd0;
      ex_rd           <= 5'd0;
      ex_rs1_data     <= '0;
      ex_rs2_data     <= '0;
      ex_imm          <= '0;
      ex_is_writeback <= 1'b0;
      ex_is_load      <= 1'b0;
    end else begin
      ex_valid        <= id_valid;
      ex_rs1_field    <= id_rs1;
      ex_rs2_field    <= id_rs2;
      ex_rd           <= id_rd;
      ex_rs1_data     <= id_rs1_data;
      ex_rs2_data     <= id_rs2_data;
      ex_imm          <= id_imm;
      ex_is_writeback <= id_valid & id_is_writeback;
      ex_is_load      <= id_valid & id_is_load;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycle_count <= 32'd0;
    end else if (stall_active && (stall_cycle_count != 32'hFFFF_FFFF)) begin
      stall_cycle_count <= stall_cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard control for the 5-stage RISC-V core.
- Captures decoded ID-stage fields and operands, and presents them to the EX stage.
- Its ex_rs1_field/ex_rs2_field outputs drive the forwarding unit's rs1/rs2 compare inputs.
- Detects load-use hazards that forwarding cannot cover, stalls PC and IF/ID, injects bubbles, and honours taken-branch flushes from EX.

Parameters:
- XLEN, 32, operand/immediate datapath width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  input  5 each  decoded register fields.
- id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
- id_imm  input  XLEN  decoded immediate.
- id_is_writeback  input  1  instruction writes rd.
- id_is_load  input  1  instruction is a load.
- ex_flush  input  1  taken branch/jump resolved in EX.
- ex_valid  output  1  EX slot holds a real instruction.
- ex_rs1_field, ex_rs2_field, ex_rd  output  5 each  registered fields; rs fields feed forwarding.
- ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered operands.
- ex_is_writeback, ex_is_load  output  1 each  registered control.
- pc_write_en  output  1  0 freezes PC.
- if_id_write_en  output  1  0 freezes the IF/ID register.
- stall_active  output  1  hazard stall in progress this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: all ex_* outputs 0, FSM = RUN, bubble counter = 0.
  - pc_write_en = if_id_write_en = 1; stall_active = 0.
- Hazard condition (combinational) is hz = id_valid & ex_valid & ex_is_load & ex_is_writeback & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Matching rs1 or rs2 is sufficient; the instruction's actual use of rs2 is not qualified.
- Bubble: ex_valid = 0, ex_is_writeback = 0, ex_is_load = 0, ex_rd = 0, ex_rs1_field = ex_rs2_field = 0. Data outputs are don't-care, and the implementation zeroes them.
- FSM RUN:
  - If ex_flush: next edge loads a bubble and stays in RUN. Flush overrides hz.
  - Else if hz: stall_active = 1, pc_write_en = if_id_write_en = 0. Next edge loads a bubble and sets counter = LOAD_STALL_CYCLES-1. Next state is STALL if counter > 0, else RUN.
  - Else: next edge captures all id_* fields (ex_valid = id_valid). Control bits are gated by id_valid.
- FSM STALL:
  - stall_active = 1, pc_write_en = if_id_write_en = 0. Each edge loads a bubble and decrements the counter.
  - When the counter reaches 0, the next state is RUN. The held ID instruction then re-evaluates hz (now false) and is captured.
  - ex_flush in STALL: next edge loads a bubble, clears the counter, goes to RUN, and deasserts the stall outputs in that cycle.
- Latency: a non-hazard ID instruction appears on ex_* one cycle later.
- A load-use pair separates by exactly LOAD_STALL_CYCLES bubbles.
- Outputs pc_write_en, if_id_write_en and stall_active are combinational from state, hz and ex_flush. All other outputs are registered.
- rd = x0 never causes a stall.
- Back-to-back hazards (load, then dependent load, then dependent ALU) each stall independently.
- Reset asserted mid-stall returns to the reset state at that edge, with no residual bubbles.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds port stall_cycle_count (output, 32 bits), a saturating count of cycles with stall_active = 1. It is cleared by reset and holds at 0xFFFFFFFF when saturated.
- When undefined, the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Pass-through: id_rs1=3, rs2=4, rd=5, is_writeback=1, data 0x11/0x22, no load in EX -> next cycle ex_rs1_field=3, ex_rs2_field=4, ex_rd=5, ex_rs1_data=0x11; pc_write_en=1 throughout.
- Load-use, LOAD_STALL_CYCLES=1: lw x5 in EX, ID add uses rs1=5 -> one cycle pc_write_en=0, if_id_write_en=0, stall_active=1; next cycle ex_valid=0; following cycle ex_rs1_field=5, ex_valid=1.
- Load-use, LOAD_STALL_CYCLES=3: same stimulus -> exactly 3 stall cycles and 3 consecutive bubbles, then the add is captured.
- No stall: load with ex_rd=0 and ID rs1=0, or a non-load writeback with ex_rd=5 matching rs2=5 -> pc_write_en stays 1, no bubble.
- Flush priority: hz and ex_flush asserted together -> pc_write_en=1, bubble loaded, FSM in RUN. ex_flush in the second STALL cycle (LOAD_STALL_CYCLES=3) -> stall ends next cycle.
- Reset mid-stall, with HAZARD_STATS_EN defined: reset during STALL -> next cycle all ex_* = 0, stall_active=0, stall_cycle_count=0.
